// File: rtl/vga_frame_scanner_pkg.sv
// Shared definitions for the VGA frame scanner: colour codes, default 640x480@60 timing,
// cell geometry, raster phase encoding and the per-pixel flag bundle carried down the pipeline.
package vga_frame_scanner_pkg;

    localparam logic [2:0] COLOR_BLACK   = 3'b000;
    localparam logic [2:0] COLOR_BLUE    = 3'b001;
    localparam logic [2:0] COLOR_GREEN   = 3'b010;
    localparam logic [2:0] COLOR_CYAN    = 3'b011;
    localparam logic [2:0] COLOR_RED     = 3'b100;
    localparam logic [2:0] COLOR_MAGENTA = 3'b101;
    localparam logic [2:0] COLOR_YELLOW  = 3'b110;
    localparam logic [2:0] COLOR_WHITE   = 3'b111;

    localparam int H_VIS_DEF  = 640;
    localparam int H_FP_DEF   = 16;
    localparam int H_SYNC_DEF = 96;
    localparam int H_BP_DEF   = 48;
    localparam int V_VIS_DEF  = 480;
    localparam int V_FP_DEF   = 10;
    localparam int V_SYNC_DEF = 2;
    localparam int V_BP_DEF   = 33;

    localparam int CELL_COLS  = 80;
    localparam int CELL_ROWS  = 60;
    localparam int CELL_SHIFT = 3;
    localparam int ADDR_W     = 13;
    localparam int CNT_W      = 10;
    localparam int DIV_W      = 2;

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FRONT,
        PH_SYNC,
        PH_BACK
    } phase_e;

    typedef struct packed {
        logic visible;
        logic hsync;
        logic vsync;
        logic frame_start;
        logic border;
    } pipe_t;

    localparam pipe_t PIPE_IDLE = '{visible: 1'b0, hsync: 1'b1, vsync: 1'b1,
                                    frame_start: 1'b0, border: 1'b0};

    // cell_y*80 built from two shifts so no multiplier is inferred
    function automatic logic [ADDR_W-1:0] cell_address(input logic [6:0] cell_x,
                                                       input logic [5:0] cell_y);
        logic [ADDR_W-1:0] row;
        row = {7'd0, cell_y};
        return (row << 6) + (row << 4) + {6'd0, cell_x};
    endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Pixel-tick divider, hcount/vcount raster counters and H/V phase FSMs producing raw sync/visible flags.
// With VGA_BORDER_EN defined the outermost visible rows/columns are also flagged for the white border.
module vga_sync_counter
    import vga_frame_scanner_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int H_VIS   = H_VIS_DEF,
    parameter int H_FP    = H_FP_DEF,
    parameter int H_SYNC  = H_SYNC_DEF,
    parameter int H_BP    = H_BP_DEF,
    parameter int V_VIS   = V_VIS_DEF,
    parameter int V_FP    = V_FP_DEF,
    parameter int V_SYNC  = V_SYNC_DEF,
    parameter int V_BP    = V_BP_DEF
) (
    input  logic       Clock,
    input  logic       Reset,
    output logic       tick,
    output logic [6:0] cell_x,
    output logic [5:0] cell_y,
    output pipe_t      raw
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_ACT_LAST   = CNT_W'(H_VIS - 1);
    localparam logic [CNT_W-1:0] H_FP_LAST    = CNT_W'(H_VIS + H_FP - 1);
    localparam logic [CNT_W-1:0] H_SYNC_LAST  = CNT_W'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] H_LAST       = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_ACT_LAST   = CNT_W'(V_VIS - 1);
    localparam logic [CNT_W-1:0] V_FP_LAST    = CNT_W'(V_VIS + V_FP - 1);
    localparam logic [CNT_W-1:0] V_SYNC_LAST  = CNT_W'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic [CNT_W-1:0] V_LAST       = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_BLANK_LINE = CNT_W'(V_VIS);

    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] hcount_q, hcount_d;
    logic [CNT_W-1:0] vcount_q, vcount_d;
    phase_e           h_phase_q, h_phase_d;
    phase_e           v_phase_q, v_phase_d;
    logic             line_end;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            div_q     <= '0;
            hcount_q  <= '0;
            vcount_q  <= '0;
            h_phase_q <= PH_ACTIVE;
            v_phase_q <= PH_ACTIVE;
        end else begin
            div_q     <= div_d;
            hcount_q  <= hcount_d;
            vcount_q  <= vcount_d;
            h_phase_q <= h_phase_d;
            v_phase_q <= v_phase_d;
        end
    end

    always_comb begin
        tick     = (div_q == DIV_LAST);
        line_end = tick && (hcount_q == H_LAST);
        div_d    = tick ? '0 : div_q + 1'b1;
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (tick) begin
            hcount_d = line_end ? '0 : hcount_q + 1'b1;
        end
        if (line_end) begin
            vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
        end
    end

    // Phases step on the same tick as the counter crossing, so they always agree with hcount/vcount
    always_comb begin
        h_phase_d = h_phase_q;
        v_phase_d = v_phase_q;
        if (tick) begin
            case (h_phase_q)
                PH_ACTIVE: if (hcount_q == H_ACT_LAST)  h_phase_d = PH_FRONT;
                PH_FRONT:  if (hcount_q == H_FP_LAST)   h_phase_d = PH_SYNC;
                PH_SYNC:   if (hcount_q == H_SYNC_LAST) h_phase_d = PH_BACK;
                default:   if (line_end)                h_phase_d = PH_ACTIVE;
            endcase
        end
        if (line_end) begin
            case (v_phase_q)
                PH_ACTIVE: if (vcount_q == V_ACT_LAST)  v_phase_d = PH_FRONT;
                PH_FRONT:  if (vcount_q == V_FP_LAST)   v_phase_d = PH_SYNC;
                PH_SYNC:   if (vcount_q == V_SYNC_LAST) v_phase_d = PH_BACK;
                default:   if (vcount_q == V_LAST)      v_phase_d = PH_ACTIVE;
            endcase
        end
    end

    always_comb begin
        cell_x          = hcount_q[9:3];
        cell_y          = vcount_q[8:3];
        raw.visible     = (h_phase_q == PH_ACTIVE) && (v_phase_q == PH_ACTIVE);
        raw.hsync       = (h_phase_q != PH_SYNC);
        raw.vsync       = (v_phase_q != PH_SYNC);
        raw.frame_start = (hcount_q == '0) && (vcount_q == V_BLANK_LINE);
`ifdef VGA_BORDER_EN
        raw.border      = (hcount_q == '0) || (hcount_q == H_ACT_LAST) ||
                          (vcount_q == '0) || (vcount_q == V_ACT_LAST);
`else
        raw.border      = 1'b0;
`endif
    end

endmodule

// File: rtl/vga_frame_scanner.sv
// VGA read side of the 80x60-cell video RAM: cell address fetch, two-tick colour/sync pipeline, frame-start pulse.
// Optional VGA_BORDER_EN white border is flagged by vga_sync_counter; latency is identical in both builds.
module vga_frame_scanner
    import vga_frame_scanner_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int H_VIS   = H_VIS_DEF,
    parameter int H_FP    = H_FP_DEF,
    parameter int H_SYNC  = H_SYNC_DEF,
    parameter int H_BP    = H_BP_DEF,
    parameter int V_VIS   = V_VIS_DEF,
    parameter int V_FP    = V_FP_DEF,
    parameter int V_SYNC  = V_SYNC_DEF,
    parameter int V_BP    = V_BP_DEF
) (
    input  logic              Clock,
    input  logic              Reset,
    output logic [ADDR_W-1:0] oReadAddress,
    input  logic [2:0]        iReadData,
    output logic [2:0]        oRGB,
    output logic              oHSync,
    output logic              oVSync,
    output logic              oFrameStart
);

    logic              tick;
    logic [6:0]        cell_x;
    logic [5:0]        cell_y;
    pipe_t             raw;
    logic [ADDR_W-1:0] addr_q, addr_d;
    pipe_t             stage1_q, stage1_d, stage2_q, stage2_d;
    logic [2:0]        data_q, data_d, rgb_q, rgb_d;
    logic              hsync_q, hsync_d, vsync_q, vsync_d;
    logic              frame_start_q, frame_start_d;

    vga_sync_counter #(
        .CLK_DIV (CLK_DIV),
        .H_VIS   (H_VIS),
        .H_FP    (H_FP),
        .H_SYNC  (H_SYNC),
        .H_BP    (H_BP),
        .V_VIS   (V_VIS),
        .V_FP    (V_FP),
        .V_SYNC  (V_SYNC),
        .V_BP    (V_BP)
    ) u_sync (
        .Clock  (Clock),
        .Reset  (Reset),
        .tick   (tick),
        .cell_x (cell_x),
        .cell_y (cell_y),
        .raw    (raw)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            addr_q        <= '0;
            stage1_q      <= PIPE_IDLE;
            stage2_q      <= PIPE_IDLE;
            data_q        <= COLOR_BLACK;
            rgb_q         <= COLOR_BLACK;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            addr_q        <= addr_d;
            stage1_q      <= stage1_d;
            stage2_q      <= stage2_d;
            data_q        <= data_d;
            rgb_q         <= rgb_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Address is frozen during blanking; the colour select keys off visible first so RAM X never leaks out
    always_comb begin
        addr_d        = addr_q;
        stage1_d      = stage1_q;
        stage2_d      = stage2_q;
        data_d        = data_q;
        rgb_d         = rgb_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        frame_start_d = 1'b0;
        if (tick) begin
            if (raw.visible) begin
                addr_d = cell_address(cell_x, cell_y);
            end
            stage1_d      = raw;
            stage2_d      = stage1_q;
            data_d        = iReadData;
            rgb_d         = !stage2_q.visible ? COLOR_BLACK :
                            (stage2_q.border ? COLOR_WHITE : data_q);
            hsync_d       = stage2_q.hsync;
            vsync_d       = stage2_q.vsync;
            frame_start_d = stage2_q.frame_start;
        end
    end

    assign oReadAddress = addr_q;
    assign oRGB         = rgb_q;
    assign oHSync       = hsync_q;
    assign oVSync       = vsync_q;
    assign oFrameStart  = frame_start_q;

endmodule

// File: tb/tb_vga_frame_scanner.sv
// Bench for vga_frame_scanner: random video RAM contents, a registered RAM model and a raster-level
// reference model checked on every Clock; geometry is shortened vertically to keep the run short.
module tb_vga_frame_scanner;
    import vga_frame_scanner_pkg::*;

    localparam int CLK_DIV     = 2;
    localparam int H_VIS       = 640;
    localparam int H_FP        = 16;
    localparam int H_SYNC      = 96;
    localparam int H_BP        = 48;
    localparam int V_VIS       = 16;
    localparam int V_FP        = 1;
    localparam int V_SYNC      = 2;
    localparam int V_BP        = 1;
    localparam int H_TOTAL     = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL     = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int FRAME_TICKS = H_TOTAL * V_TOTAL;
    localparam int RESET_TICK  = 4 * H_TOTAL + 300;

    logic        clock;
    logic        reset;
    logic [12:0] read_address;
    logic [2:0]  read_data;
    logic [2:0]  rgb;
    logic        hsync;
    logic        vsync;
    logic        frame_start;

    logic [2:0]  mem [0:8191];
    logic [2:0]  ram_q;
    logic        x_inject;

    int compared;
    int mismatched;
    int edges_done;
    int model_addr;
    int fs_count;

    vga_frame_scanner #(
        .CLK_DIV (CLK_DIV),
        .H_VIS   (H_VIS),
        .H_FP    (H_FP),
        .H_SYNC  (H_SYNC),
        .H_BP    (H_BP),
        .V_VIS   (V_VIS),
        .V_FP    (V_FP),
        .V_SYNC  (V_SYNC),
        .V_BP    (V_BP)
    ) dut (
        .Clock        (clock),
        .Reset        (reset),
        .oReadAddress (read_address),
        .iReadData    (read_data),
        .oRGB         (rgb),
        .oHSync       (hsync),
        .oVSync       (vsync),
        .oFrameStart  (frame_start)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Registered RAM: data valid one Clock after the address changes; X driven when the pixel is blank
    always @(posedge clock) ram_q <= mem[read_address];
    assign read_data = x_inject ? 3'bxxx : ram_q;

    function automatic int pixel_x(input int p);
        return p % H_TOTAL;
    endfunction

    function automatic int pixel_y(input int p);
        return (p / H_TOTAL) % V_TOTAL;
    endfunction

    function automatic bit pixel_visible(input int p);
        return (pixel_x(p) < H_VIS) && (pixel_y(p) < V_VIS);
    endfunction

    function automatic int pixel_cell(input int p);
        return (pixel_y(p) / 8) * 80 + pixel_x(p) / 8;
    endfunction

    function automatic logic [2:0] pixel_colour(input int p);
        if (!pixel_visible(p)) return COLOR_BLACK;
`ifdef VGA_BORDER_EN
        if (pixel_x(p) == 0 || pixel_x(p) == H_VIS - 1 || pixel_y(p) == 0 || pixel_y(p) == V_VIS - 1)
            return COLOR_WHITE;
`endif
        return mem[pixel_cell(p)];
    endfunction

    task automatic compare(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h at time %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkReset(input string tag);
        compare({tag, "_rgb"},   {13'd0, rgb},          16'd0);
        compare({tag, "_hsync"}, {15'd0, hsync},        16'd1);
        compare({tag, "_vsync"}, {15'd0, vsync},        16'd1);
        compare({tag, "_addr"},  {3'd0, read_address},  16'd0);
        compare({tag, "_fs"},    {15'd0, frame_start},  16'd0);
    endtask

    // Output after t ticks shows pixel t-3 of the raster (pipeline of two ticks after the address tick)
    task automatic checkOutput();
        int         t;
        int         p;
        bit         tick_edge;
        logic [2:0] exp_rgb;
        logic       exp_hs;
        logic       exp_vs;
        logic       exp_fs;
        t         = edges_done / CLK_DIV;
        tick_edge = (edges_done > 0) && (edges_done % CLK_DIV == 0);
        p         = t - 3;
        exp_rgb   = COLOR_BLACK;
        exp_hs    = 1'b1;
        exp_vs    = 1'b1;
        exp_fs    = 1'b0;
        if (p >= 0) begin
            exp_rgb = pixel_colour(p);
            exp_hs  = !(pixel_x(p) >= H_VIS + H_FP && pixel_x(p) < H_VIS + H_FP + H_SYNC);
            exp_vs  = !(pixel_y(p) >= V_VIS + V_FP && pixel_y(p) < V_VIS + V_FP + V_SYNC);
            exp_fs  = tick_edge && pixel_x(p) == 0 && pixel_y(p) == V_VIS;
        end
        if (frame_start === 1'b1) fs_count++;
        compare("rgb",         {13'd0, rgb},         {13'd0, exp_rgb});
        compare("hsync",       {15'd0, hsync},       {15'd0, exp_hs});
        compare("vsync",       {15'd0, vsync},       {15'd0, exp_vs});
        compare("frame_start", {15'd0, frame_start}, {15'd0, exp_fs});
        compare("address",     {3'd0, read_address}, 16'(model_addr));
    endtask

    task automatic applyStimulus(input int cycles);
        int q;
        int next_edge;
        int pix;
        repeat (cycles) begin
            @(posedge clock);
            edges_done++;
            if (edges_done % CLK_DIV == 0) begin
                q = edges_done / CLK_DIV - 1;
                if (pixel_visible(q)) model_addr = pixel_cell(q);
            end
            @(negedge clock);
            checkOutput();
            next_edge = edges_done + 1;
            if (next_edge % CLK_DIV == 0) begin
                pix      = next_edge / CLK_DIV - 2;
                x_inject = (pix < 0) || !pixel_visible(pix);
            end else begin
                x_inject = 1'b0;
            end
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        edges_done = 0;
        model_addr = 0;
        fs_count   = 0;
        x_inject   = 1'b0;
        reset      = 1'b0;
        for (int a = 0; a < 8192; a++) mem[a] = 3'($urandom_range(0, 7));
        mem[0]   = COLOR_RED;
        mem[81]  = COLOR_BLUE;
        mem[159] = COLOR_WHITE;

        repeat (5) @(negedge clock);
        checkReset("reset_hold");
        $display("[TB] releasing reset, scanning to line 4 pixel 300");
        reset = 1'b1;
        applyStimulus(RESET_TICK * CLK_DIV);
        compare("fs_count_first_run", 16'(fs_count), 16'd0);

        #2 reset = 1'b0;
        #1 checkReset("reset_mid_frame");
        repeat (3) @(negedge clock);
        checkReset("reset_mid_hold");

        $display("[TB] releasing reset, scanning through two frame starts");
        reset      = 1'b1;
        edges_done = 0;
        model_addr = 0;
        fs_count   = 0;
        x_inject   = 1'b0;
        applyStimulus((FRAME_TICKS + V_VIS * H_TOTAL + 10) * CLK_DIV);
        compare("fs_count_two_frames", 16'(fs_count), 16'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
